// File: rtl/sr_drv_pkg.sv
// rtl/sr_drv_pkg.sv - shared types and default constants for the SR latch command driver
package sr_drv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SET_P = 2'd1,
    CLR_P = 2'd2,
    HOLD  = 2'd3
  } state_e;

  typedef enum logic {
    REQ_SET = 1'b0,
    REQ_CLR = 1'b1
  } req_kind_e;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_PULSE_CYCLES    = 2;
  localparam int DEF_HOLDOFF_CYCLES  = 3;
  localparam int DEF_CNT_W           = 8;

endpackage

// File: rtl/sr_input_cond.sv
// rtl/sr_input_cond.sv - synchronizer, debounce filter and rising-edge request for one raw input
module sr_input_cond
  import sr_drv_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic req
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   filt_q, filt_d;
  logic                   filt_prev_q, filt_prev_d;
  logic                   req_q, req_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];
  assign req    = req_q;

  // Shift the raw input in, flip the filtered level only after a full run of mismatches.
  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], din};
    filt_d      = filt_q;
    cnt_d       = '0;
    if (synced != filt_q) begin
      if (cnt_q == DEB_LAST) begin
        filt_d = synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
    filt_prev_d = filt_q;
    // Only a 0->1 transition of the filtered level is a request.
    req_d       = filt_q & ~filt_prev_q;
  end

  // Conditioning state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      cnt_q       <= cnt_d;
      filt_q      <= filt_d;
      filt_prev_q <= filt_prev_d;
      req_q       <= req_d;
    end
  end

endmodule

// File: rtl/sr_latch_driver.sv
// rtl/sr_latch_driver.sv - turns raw set/clear requests into exclusive fixed-width latch pulses
module sr_latch_driver
  import sr_drv_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int HOLDOFF_CYCLES  = DEF_HOLDOFF_CYCLES,
  parameter int CNT_W           = DEF_CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic set_in,
  input  logic clr_in,
  output logic s_out,
  output logic r_out,
  output logic busy,
  output logic q_model,
  output logic conflict_err
);

  localparam int               HOLD_INIT  = (HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_INIT);

  logic             set_req, clr_req;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             s_q, s_d, r_q, r_d;
  logic             q_model_q, q_model_d;
  logic             conflict_q, conflict_d;
  logic             pend_valid_q, pend_valid_d;
  req_kind_e        pend_kind_q, pend_kind_d;
  logic             start;
  req_kind_e        start_kind;

  sr_input_cond #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_set_cond (
    .clk(clk),
    .rst(rst),
    .din(set_in),
    .req(set_req)
  );

  sr_input_cond #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_clr_cond (
    .clk(clk),
    .rst(rst),
    .din(clr_in),
    .req(clr_req)
  );

  assign s_out        = s_q;
  assign r_out        = r_q;
  assign busy         = (state_q != IDLE);
  assign q_model      = q_model_q;
  assign conflict_err = conflict_q;

  // Next state, pulse outputs, model update and pending-slot bookkeeping.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    s_d          = 1'b0;
    r_d          = 1'b0;
    q_model_d    = q_model_q;
    conflict_d   = 1'b0;
    pend_valid_d = pend_valid_q;
    pend_kind_d  = pend_kind_q;
    start        = 1'b0;
    start_kind   = REQ_SET;

    case (state_q)
      IDLE: begin
        if (set_req || clr_req) begin
          // Clear wins a tie; a fresh request displaces anything left pending.
          start        = 1'b1;
          start_kind   = clr_req ? REQ_CLR : REQ_SET;
          conflict_d   = (set_req && clr_req) || pend_valid_q;
          pend_valid_d = 1'b0;
        end else if (pend_valid_q) begin
          start        = 1'b1;
          start_kind   = pend_kind_q;
          pend_valid_d = 1'b0;
        end
      end
      SET_P, CLR_P: begin
        if (cnt_q == '0) begin
          q_model_d = (state_q == SET_P);
          if (HOLDOFF_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          s_d   = (state_q == SET_P);
          r_d   = (state_q == CLR_P);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      cnt_d = PULSE_LOAD;
      if (start_kind == REQ_CLR) begin
        state_d = CLR_P;
        r_d     = 1'b1;
      end else begin
        state_d = SET_P;
        s_d     = 1'b1;
      end
    end

    // Requests arriving mid-sequence park in the one-deep slot, last one wins.
    if ((state_q != IDLE) && (set_req || clr_req)) begin
      pend_valid_d = 1'b1;
      pend_kind_d  = clr_req ? REQ_CLR : REQ_SET;
      conflict_d   = pend_valid_q || (set_req && clr_req);
    end
  end

  // Registered FSM, counter, outputs and pending slot; reset drops pulses without a clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      s_q          <= 1'b0;
      r_q          <= 1'b0;
      q_model_q    <= 1'b0;
      conflict_q   <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_kind_q  <= REQ_SET;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      s_q          <= s_d;
      r_q          <= r_d;
      q_model_q    <= q_model_d;
      conflict_q   <= conflict_d;
      pend_valid_q <= pend_valid_d;
      pend_kind_q  <= pend_kind_d;
    end
  end

endmodule
